// File: rtl/rvs_xrf_wb_buffer.sv
// rvs_xrf_wb_buffer
//   Collects scalar-register (XRF) writebacks retired by the vector unit and
//   replays them one per cycle into the shared XRF write port whenever the
//   scalar pipeline leaves that port free.
//
//   Optional feature macro: RVS_XRF_WB_PERF_EN adds the wb_stall_cnt port
//   and a saturating counter of cycles where a write was pending but the
//   port was not granted.
//
// Ports
//   clk                   sole clock, rising edge
//   rst_n                 asynchronous reset, ACTIVE-HIGH despite its name
//   rt_xrf_valid_rvv2rvs  per-lane writeback valid, lane 0 oldest
//   rt_xrf_rvv2rvs        per-lane {index[4:0], data[XLEN-1:0]}
//   rt_xrf_ready_rvs2rvv  per-lane accept, derived from registered fill level
//   xrf_wr_valid          head entry pending
//   xrf_wr_addr           head entry register index (0 while empty)
//   xrf_wr_data           head entry data (0 while empty)
//   xrf_wr_grant          XRF port granted to this block this cycle
//   wb_idle               buffer empty
//   wb_stall_cnt          stall cycle counter (RVS_XRF_WB_PERF_EN only)

`ifndef NUM_RT_UOP
`define NUM_RT_UOP 4
`endif

module rvs_xrf_wb_buffer #(
  parameter int NUM_PORT = `NUM_RT_UOP,
  parameter int DEPTH    = 8,
  parameter int XLEN     = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_PORT-1:0]          rt_xrf_valid_rvv2rvs,
  input  logic [NUM_PORT*(5+XLEN)-1:0] rt_xrf_rvv2rvs,
  output logic [NUM_PORT-1:0]          rt_xrf_ready_rvs2rvv,
  output logic                         xrf_wr_valid,
  output logic [4:0]                   xrf_wr_addr,
  output logic [XLEN-1:0]              xrf_wr_data,
  input  logic                         xrf_wr_grant,
  output logic                         wb_idle
`ifdef RVS_XRF_WB_PERF_EN
  ,
  output logic [15:0]                  wb_stall_cnt
`endif
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int LANE_W = 5 + XLEN;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  // Storage is not reset: the head outputs are masked while empty, so stale
  // contents are never observable.
  logic [4:0]       r_mem_idx  [DEPTH];
  logic [XLEN-1:0]  r_mem_data [DEPTH];

  logic [CNT_W-1:0] w_free;
  logic [CNT_W-1:0] w_nstore;
  logic             w_deq;
  logic [NUM_PORT-1:0] w_store;
  logic [4:0]       w_idx  [NUM_PORT];
  logic [XLEN-1:0]  w_dat  [NUM_PORT];
  logic [PTR_W-1:0] w_slot [NUM_PORT];

  // Lanes that hand over index 0 are accepted but dropped (x0 is not
  // writable). The running store count gives each stored lane its slot
  // offset, so dropped lanes leave no hole in the FIFO.
  always_comb begin
    w_free   = DEPTH_C - r_count;
    w_nstore = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      w_idx[i]  = rt_xrf_rvv2rvs[i*LANE_W+XLEN +: 5];
      w_dat[i]  = rt_xrf_rvv2rvs[i*LANE_W +: XLEN];
      rt_xrf_ready_rvs2rvv[i] = (w_free > CNT_W'(i));
      w_store[i] = rt_xrf_valid_rvv2rvs[i] & rt_xrf_ready_rvs2rvv[i] &
                   (w_idx[i] != 5'd0);
      w_slot[i]  = r_wptr + w_nstore[PTR_W-1:0];
      w_nstore   = w_nstore + CNT_W'(w_store[i]);
    end
  end

  assign xrf_wr_valid = (r_count != '0);
  assign wb_idle      = (r_count == '0);
  assign w_deq        = xrf_wr_valid & xrf_wr_grant;
  assign xrf_wr_addr  = xrf_wr_valid ? r_mem_idx[r_rptr]  : 5'd0;
  assign xrf_wr_data  = xrf_wr_valid ? r_mem_data[r_rptr] : '0;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // Pointer width equals log2(DEPTH), so the adds wrap naturally.
      r_wptr  <= r_wptr + w_nstore[PTR_W-1:0];
      if (w_deq) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= r_count + w_nstore - CNT_W'(w_deq);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORT; i++) begin
      if (w_store[i]) begin
        r_mem_idx[w_slot[i]]  <= w_idx[i];
        r_mem_data[w_slot[i]] <= w_dat[i];
      end
    end
  end

`ifdef RVS_XRF_WB_PERF_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_stall_cnt <= '0;
    end else if (xrf_wr_valid && !xrf_wr_grant && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign wb_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_rvs_xrf_wb_buffer.sv
// Scoreboard bench for rvs_xrf_wb_buffer: the driver pushes every entry it
// expects to be stored; a monitor pops and compares on each granted write.
module tb_rvs_xrf_wb_buffer;
  localparam int NP   = 4;
  localparam int XLEN = 32;
  localparam int LW   = 5 + XLEN;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [NP-1:0]       valid = '0;
  logic [NP*LW-1:0]    lanes = '0;
  logic [NP-1:0]       ready;
  logic                xrf_wr_valid;
  logic [4:0]          xrf_wr_addr;
  logic [XLEN-1:0]     xrf_wr_data;
  logic                xrf_wr_grant = 1'b0;
  logic                wb_idle;
`ifdef RVS_XRF_WB_PERF_EN
  logic [15:0]         wb_stall_cnt;
`endif

  rvs_xrf_wb_buffer #(.NUM_PORT(NP), .DEPTH(8), .XLEN(XLEN)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .rt_xrf_valid_rvv2rvs (valid),
    .rt_xrf_rvv2rvs       (lanes),
    .rt_xrf_ready_rvs2rvv (ready),
    .xrf_wr_valid         (xrf_wr_valid),
    .xrf_wr_addr          (xrf_wr_addr),
    .xrf_wr_data          (xrf_wr_data),
    .xrf_wr_grant         (xrf_wr_grant),
    .wb_idle              (wb_idle)
`ifdef RVS_XRF_WB_PERF_EN
    ,
    .wb_stall_cnt         (wb_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [LW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
  endtask

  function automatic logic [NP-1:0][4:0] seq_idx(input int base);
    logic [NP-1:0][4:0] r;
    for (int i = 0; i < NP; i++) r[i] = 5'(base + i);
    return r;
  endfunction

  function automatic logic [NP-1:0][31:0] seq_dat(input int base);
    logic [NP-1:0][31:0] r;
    for (int i = 0; i < NP; i++) r[i] = 32'h5A00_0000 | 32'(base + i);
    return r;
  endfunction

  // Called at posedge+1; returns at the next posedge+1 with valid dropped.
  task automatic send(input logic [NP-1:0] v, input logic [NP-1:0][4:0] idx,
                      input logic [NP-1:0][31:0] dat, input logic [NP-1:0] exp_rdy,
                      input string nm);
    for (int i = 0; i < NP; i++) begin
      lanes[i*LW +: LW] = {idx[i], dat[i]};
      if (v[i] && exp_rdy[i] && idx[i] != 5'd0) exp_q.push_back({idx[i], dat[i]});
    end
    valid = v;
    #1 chk(nm, 64'(ready), 64'(exp_rdy));
    @(posedge clk);
    #1 valid = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      if (wb_idle) break;
      cyc(1);
    end
    chk(nm, 64'(wb_idle), 64'd1);
  endtask

  // Monitor: every granted write must match the oldest expected entry.
  initial begin
    logic [LW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n && xrf_wr_valid && xrf_wr_grant) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, required none",
                   xrf_wr_addr, xrf_wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(xrf_wr_addr), 64'(e[LW-1:XLEN]));
          chk("wr_data", 64'(xrf_wr_data), 64'(e[XLEN-1:0]));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_state(input string nm);
    chk({nm, "_valid"}, 64'(xrf_wr_valid), 64'd0);
    chk({nm, "_idle"},  64'(wb_idle),      64'd1);
    chk({nm, "_ready"}, 64'(ready),        64'hF);
    chk({nm, "_addr"},  64'(xrf_wr_addr),  64'd0);
    chk({nm, "_data"},  64'(xrf_wr_data),  64'd0);
`ifdef RVS_XRF_WB_PERF_EN
    chk({nm, "_stall"}, 64'(wb_stall_cnt), 64'd0);
`endif
  endtask

  initial begin
    // Reset state, during and after reset
    cyc(2);
    chk_reset_state("in_reset");
    rst_n = 1'b0;
    cyc(1);
    chk_reset_state("post_reset");

    // Four lanes with grant: drained in order over exactly four cycles
    xrf_wr_grant = 1'b1;
    send(4'hF, seq_idx(1), {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 4'hF, "burst_ready");
    chk("burst_pending", 64'(xrf_wr_valid), 64'd1);
    cyc(4);
    chk("burst_idle", 64'(wb_idle), 64'd1);

    // Fill to full without grant, then one dequeue frees exactly one lane
    xrf_wr_grant = 1'b0;
    send(4'hF, seq_idx(1), seq_dat(1), 4'hF, "fill_first");
    send(4'hF, seq_idx(5), seq_dat(5), 4'hF, "fill_second");
    send(4'hF, seq_idx(9), seq_dat(9), 4'h0, "full_ready");
    chk("full_not_idle", 64'(wb_idle), 64'd0);
    xrf_wr_grant = 1'b1;
    cyc(1);
    xrf_wr_grant = 1'b0;
    chk("one_free_ready", 64'(ready), 64'h1);
    xrf_wr_grant = 1'b1;
    wait_idle(20, "full_drain_idle");

    // Index 0 lane accepted but dropped; remaining lanes pack without a hole
    xrf_wr_grant = 1'b0;
    send(4'h7, {5'd0, 5'd7, 5'd0, 5'd5}, seq_dat(40), 4'hF, "zero_idx_ready");
    xrf_wr_grant = 1'b1;
    cyc(2);
    chk("zero_idx_two_stored", 64'(wb_idle), 64'd1);

    // Enqueue four while dequeuing one: 4 + 4 - 1 = 7
    xrf_wr_grant = 1'b0;
    send(4'hF, seq_idx(1), seq_dat(60), 4'hF, "simul_first");
    xrf_wr_grant = 1'b1;
    send(4'hF, seq_idx(5), seq_dat(64), 4'hF, "simul_second");
    xrf_wr_grant = 1'b0;
    chk("simul_count7_ready", 64'(ready), 64'h1);
    xrf_wr_grant = 1'b1;
    wait_idle(20, "simul_drain_idle");

    // Seven entries, drain three, enqueue four: order must survive the wrap
    xrf_wr_grant = 1'b0;
    send(4'hF, seq_idx(9), seq_dat(9), 4'hF, "wrap_fill4");
    send(4'h7, seq_idx(13), seq_dat(13), 4'hF, "wrap_fill3");
    chk("wrap_count7_ready", 64'(ready), 64'h1);
    xrf_wr_grant = 1'b1;
    cyc(3);
    xrf_wr_grant = 1'b0;
    chk("wrap_count4_ready", 64'(ready), 64'hF);
    send(4'hF, seq_idx(16), seq_dat(16), 4'hF, "wrap_enq4");
    chk("wrap_full_ready", 64'(ready), 64'h0);
    xrf_wr_grant = 1'b1;
    wait_idle(20, "wrap_drain_idle");

    // Reset with five entries buffered discards them all
    xrf_wr_grant = 1'b0;
    send(4'hF, seq_idx(20), seq_dat(20), 4'hF, "rst_fill4");
    send(4'h1, seq_idx(24), seq_dat(24), 4'hF, "rst_fill1");
    chk("rst_pre_valid", 64'(xrf_wr_valid), 64'd1);
    rst_n = 1'b1;
    exp_q.delete();
    #1 chk_reset_state("mid_reset");
    cyc(1);
    rst_n = 1'b0;
    xrf_wr_grant = 1'b1;
    cyc(5);
    chk("after_reset_idle", 64'(wb_idle), 64'd1);

`ifdef RVS_XRF_WB_PERF_EN
    // Stall counter counts, saturates and holds
    rst_n = 1'b1;
    cyc(1);
    rst_n = 1'b0;
    xrf_wr_grant = 1'b0;
    send(4'h1, seq_idx(3), seq_dat(3), 4'hF, "perf_enq");
    cyc(10);
    chk("stall_cnt_10", 64'(wb_stall_cnt), 64'd10);
    cyc(70000);
    chk("stall_cnt_sat", 64'(wb_stall_cnt), 64'hFFFF);
    cyc(5);
    chk("stall_cnt_hold", 64'(wb_stall_cnt), 64'hFFFF);
    xrf_wr_grant = 1'b1;
    wait_idle(5, "perf_drain_idle");
`endif

    cyc(2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
